// File: rtl/wb_commit.sv
// rtl/wb_commit.sv - write-back commit stage: GPR file, HI/LO, LLbit and retire counter
// Read ports bypass the in-flight GPR write so ID sees it in the same cycle.
module wb_commit #(
  parameter int DW     = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [REG_AW-1:0] wb_wd,
  input  logic              wb_wreg,
  input  logic [DW-1:0]     wb_wdata,
  input  logic [DW-1:0]     wb_hi,
  input  logic [DW-1:0]     wb_lo,
  input  logic              wb_whilo,
  input  logic              wb_LLbit_we,
  input  logic              wb_LLbit_value,
  input  logic              re1,
  input  logic [REG_AW-1:0] raddr1,
  input  logic              re2,
  input  logic [REG_AW-1:0] raddr2,
  output logic [DW-1:0]     rdata1,
  output logic [DW-1:0]     rdata2,
  output logic [DW-1:0]     hi_o,
  output logic [DW-1:0]     lo_o,
  output logic              LLbit_o,
  output logic [CNT_W-1:0]  retire_cnt
);

  localparam int DEPTH = 1 << REG_AW;

  logic [DW-1:0] gpr [DEPTH];
  logic          gpr_we;
  logic          commit;

  assign gpr_we = wb_wreg && (wb_wd != '0);
  assign commit = wb_wreg | wb_whilo | wb_LLbit_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        gpr[i] <= '0;
      end
    end else if (gpr_we) begin
      gpr[wb_wd] <= wb_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_o <= '0;
      lo_o <= '0;
    end else if (wb_whilo) begin
      hi_o <= wb_hi;
      lo_o <= wb_lo;
    end
  end

  // flush wins over a same-cycle SC/LL update so a squashed LL never arms the link.
  always_ff @(posedge clk) begin
    if (rst) begin
      LLbit_o <= 1'b0;
    end else if (flush) begin
      LLbit_o <= 1'b0;
    end else if (wb_LLbit_we) begin
      LLbit_o <= wb_LLbit_value;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt <= '0;
    end else if (commit) begin
      retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    rdata1 = '0;
    if (rst || !re1 || raddr1 == '0) begin
      rdata1 = '0;
    end else if (wb_wreg && wb_wd == raddr1) begin
      rdata1 = wb_wdata;
    end else begin
      rdata1 = gpr[raddr1];
    end
  end

  always_comb begin
    rdata2 = '0;
    if (rst || !re2 || raddr2 == '0) begin
      rdata2 = '0;
    end else if (wb_wreg && wb_wd == raddr2) begin
      rdata2 = wb_wdata;
    end else begin
      rdata2 = gpr[raddr2];
    end
  end

endmodule

// File: tb/tb_wb_commit.sv
// tb/tb_wb_commit.sv - directed bench for wb_commit
// Two instances share stimulus: default widths, and a 4-bit counter for the wrap case.
module tb_wb_commit;

  logic        clk = 1'b0;
  logic        rst, flush, wb_wreg, wb_whilo, wb_LLbit_we, wb_LLbit_value, re1, re2;
  logic [4:0]  wb_wd, raddr1, raddr2;
  logic [31:0] wb_wdata, wb_hi, wb_lo;
  logic [31:0] rdata1, rdata2, hi_o, lo_o, retire_cnt;
  logic        LLbit_o;
  logic [31:0] rdata1_b, rdata2_b, hi_b, lo_b;
  logic        ll_b;
  logic [3:0]  cnt4;
  int          total = 0;
  int          passed = 0;

  always #5 clk = ~clk;

  wb_commit dut (
    .clk(clk), .rst(rst), .flush(flush), .wb_wd(wb_wd), .wb_wreg(wb_wreg),
    .wb_wdata(wb_wdata), .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_whilo(wb_whilo),
    .wb_LLbit_we(wb_LLbit_we), .wb_LLbit_value(wb_LLbit_value),
    .re1(re1), .raddr1(raddr1), .re2(re2), .raddr2(raddr2),
    .rdata1(rdata1), .rdata2(rdata2), .hi_o(hi_o), .lo_o(lo_o),
    .LLbit_o(LLbit_o), .retire_cnt(retire_cnt)
  );

  wb_commit #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .flush(flush), .wb_wd(wb_wd), .wb_wreg(wb_wreg),
    .wb_wdata(wb_wdata), .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_whilo(wb_whilo),
    .wb_LLbit_we(wb_LLbit_we), .wb_LLbit_value(wb_LLbit_value),
    .re1(re1), .raddr1(raddr1), .re2(re2), .raddr2(raddr2),
    .rdata1(rdata1_b), .rdata2(rdata2_b), .hi_o(hi_b), .lo_o(lo_b),
    .LLbit_o(ll_b), .retire_cnt(cnt4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic idle();
    rst = 0; flush = 0; wb_wreg = 0; wb_wd = 0; wb_wdata = 0; wb_whilo = 0;
    wb_hi = 0; wb_lo = 0; wb_LLbit_we = 0; wb_LLbit_value = 0;
    re1 = 0; re2 = 0; raddr1 = 0; raddr2 = 0;
  endtask

  // Advance one rising edge, then settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] wd, input logic [31:0] d);
    wb_wreg = 1; wb_wd = wd; wb_wdata = d;
  endtask

  task automatic rd1(input logic [4:0] a);
    re1 = 1; raddr1 = a;
  endtask

  initial begin
    idle();
    rst = 1;
    step();
    rst = 0;
    #1;
    chk("reset_cnt", retire_cnt, 32'd0);
    chk("reset_hi", hi_o, 32'd0);
    chk("reset_ll", 32'(LLbit_o), 32'd0);

    // Preload state, then reset with a write in flight.
    wr(5'd3, 32'hAAAA5555); wb_whilo = 1; wb_hi = 32'h11; wb_lo = 32'h22;
    wb_LLbit_we = 1; wb_LLbit_value = 1;
    step();
    idle();
    #1;
    chk("preload_hi", hi_o, 32'h11);
    chk("preload_ll", 32'(LLbit_o), 32'd1);
    chk("preload_cnt", retire_cnt, 32'd1);
    rd1(5'd3);
    #1;
    chk("preload_r3", rdata1, 32'hAAAA5555);
    rst = 1; wr(5'd4, 32'h0000BEEF); re2 = 1; raddr2 = 5'd4;
    #1;
    chk("rst_forces_rd1", rdata1, 32'd0);
    chk("rst_forces_rd2", rdata2, 32'd0);
    step();
    idle(); rd1(5'd3); re2 = 1; raddr2 = 5'd4;
    #1;
    chk("after_rst_r3", rdata1, 32'd0);
    chk("rst_write_dropped", rdata2, 32'd0);
    chk("after_rst_hi", hi_o, 32'd0);
    chk("after_rst_lo", lo_o, 32'd0);
    chk("after_rst_ll", 32'(LLbit_o), 32'd0);
    chk("after_rst_cnt", retire_cnt, 32'd0);

    // Write then read back; read enable gates the port.
    idle(); wr(5'd5, 32'hDEADBEEF);
    step();
    idle(); rd1(5'd5);
    #1;
    chk("r5_read", rdata1, 32'hDEADBEEF);
    re1 = 0;
    #1;
    chk("r5_re_off", rdata1, 32'd0);
    chk("cnt_1", retire_cnt, 32'd1);

    // Same-cycle write-through on both ports.
    wr(5'd7, 32'h12345678); rd1(5'd7); re2 = 1; raddr2 = 5'd7;
    #1;
    chk("bypass_rd1", rdata1, 32'h12345678);
    chk("bypass_rd2", rdata2, 32'h12345678);
    step();
    idle(); rd1(5'd7);
    #1;
    chk("r7_stored", rdata1, 32'h12345678);
    chk("cnt_2", retire_cnt, 32'd2);

    // $0 stays zero but the attempt still retires.
    wr(5'd0, 32'hFFFFFFFF); rd1(5'd0);
    #1;
    chk("r0_bypass", rdata1, 32'd0);
    step();
    idle(); rd1(5'd0);
    #1;
    chk("r0_after", rdata1, 32'd0);
    chk("cnt_3", retire_cnt, 32'd3);

    // HI/LO have no bypass; visible after the edge.
    wb_whilo = 1; wb_hi = 32'h1; wb_lo = 32'h2;
    #1;
    chk("hi_no_bypass", hi_o, 32'd0);
    step();
    idle();
    #1;
    chk("hi_commit", hi_o, 32'h1);
    chk("lo_commit", lo_o, 32'h2);
    chk("cnt_4", retire_cnt, 32'd4);

    // LLbit: flush beats a same-cycle set.
    wb_LLbit_we = 1; wb_LLbit_value = 1; flush = 1;
    step();
    idle();
    #1;
    chk("ll_flush_wins", 32'(LLbit_o), 32'd0);
    chk("cnt_5", retire_cnt, 32'd5);
    wb_LLbit_we = 1; wb_LLbit_value = 1;
    step();
    idle();
    #1;
    chk("ll_set", 32'(LLbit_o), 32'd1);
    flush = 1;
    step();
    idle();
    #1;
    chk("ll_flush_alone", 32'(LLbit_o), 32'd0);
    chk("cnt_flush_idle", retire_cnt, 32'd6);

    // flush does not squash a GPR commit.
    wr(5'd9, 32'hCAFEF00D); flush = 1;
    step();
    idle(); rd1(5'd9);
    #1;
    chk("flush_keeps_gpr", rdata1, 32'hCAFEF00D);
    chk("cnt_7", retire_cnt, 32'd7);
    step();
    chk("idle_holds_cnt", retire_cnt, 32'd7);
    chk("idle_holds_hi", hi_o, 32'h1);

    // 4-bit counter wrap over 16 commits with one idle cycle in the middle.
    idle(); rst = 1;
    step();
    idle();
    for (int i = 0; i < 16; i++) begin
      wr(5'd0, 32'h0);
      step();
      idle();
      if (i == 7) begin
        #1;
        chk("cnt4_8", 32'(cnt4), 32'd8);
        step();
        chk("cnt4_idle", 32'(cnt4), 32'd8);
      end
      if (i == 14) chk("cnt4_15", 32'(cnt4), 32'd15);
    end
    #1;
    chk("cnt4_wrap", 32'(cnt4), 32'd0);
    chk("cnt32_16", retire_cnt, 32'd16);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
